// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: mic clock divider, input synchronizer, CIC decimator and
// saturating single-entry stream output. Define PDM_DROP_COUNT_EN to add the drop_cnt port.

package loudness_meter_pkg;
    typedef logic signed [15:0] data_t;
endpackage

module pdm_cic_decimator #(
    parameter int CLK_HALF = 25,
    parameter int DECIM    = 64,
    parameter int ORDER    = 3,
    parameter int SETTLE   = ORDER
) (
    input  logic                                         clk,
    input  logic                                         rst,
    output logic                                         mic_clk,
    input  logic                                         pdm_data,
    output logic [$bits(loudness_meter_pkg::data_t)-1:0] data,
    output logic                                         data_valid,
    input  logic                                         data_ready
`ifdef PDM_DROP_COUNT_EN
    ,
    output logic [15:0]                                  drop_cnt
`endif
);

    localparam int DW    = $bits(loudness_meter_pkg::data_t);
    localparam int LOG_D = $clog2(DECIM);
    localparam int W     = ORDER * LOG_D + 2;
    localparam int SHIFT = (W > DW + 1) ? W - (DW + 1) : 0;
    localparam int EW    = (W > DW + 2) ? W : DW + 2;
    localparam int DIV_W = $clog2(CLK_HALF);
    localparam int SET_W = $clog2(SETTLE + 2);

    localparam logic signed [EW-1:0] SAT_HI = EW'((2 ** (DW - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_LO = EW'(-(2 ** (DW - 1)));

    if (CLK_HALF < 2) begin : g_bad_clk_half
        $error("pdm_cic_decimator: CLK_HALF must be >= 2");
    end
    if (DECIM < 4 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("pdm_cic_decimator: DECIM must be a power of 2 and >= 4");
    end
    if (ORDER < 1 || ORDER > 4) begin : g_bad_order
        $error("pdm_cic_decimator: ORDER must be in 1..4");
    end

    // ------------------------------------------------------------------
    // Mic clock divider and PDM tick
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             tick;

    assign div_wrap = (div_cnt == DIV_W'(CLK_HALF - 1));
    // The mic samples on its rising edge, so the bit is stable by the end of the high phase.
    assign tick     = mic_clk && div_wrap;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic pdm_meta;
    logic pdm_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            pdm_meta <= 1'b0;
            pdm_sync <= 1'b0;
        end else begin
            pdm_meta <= pdm_data;
            pdm_sync <= pdm_meta;
        end
    end

    // ------------------------------------------------------------------
    // Integrators (run at the PDM rate, wrap modulo 2^W)
    // ------------------------------------------------------------------
    logic [W-1:0] integ [ORDER];

    // NOTE: these register arrays are reset explicitly; the wrapping arithmetic is only
    // exact if every integrator and comb delay restarts from the same zero history.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) integ[i] <= '0;
        end else if (tick) begin
            integ[0] <= integ[0] + (pdm_sync ? W'(1) : {W{1'b1}});
            for (int i = 1; i < ORDER; i++) integ[i] <= integ[i] + integ[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Decimation counter and comb section (evaluated once per DECIM ticks)
    // ------------------------------------------------------------------
    logic [LOG_D-1:0] dec_cnt;
    logic             dec_fire;
    logic [W-1:0]     comb_dly [ORDER];
    logic [W-1:0]     comb_in  [ORDER];
    logic [W-1:0]     comb_res;
    logic [W-1:0]     comb_q;
    logic             comb_vld;

    assign dec_fire = tick && (dec_cnt == LOG_D'(DECIM - 1));

    // NOTE: every output of a combinational block is assigned before any conditional use,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin : comb_chain
        logic [W-1:0] acc;
        acc = integ[ORDER-1];
        for (int i = 0; i < ORDER; i++) begin
            comb_in[i] = acc;
            acc        = acc - comb_dly[i];
        end
        comb_res = acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt  <= '0;
            comb_q   <= '0;
            comb_vld <= 1'b0;
            for (int i = 0; i < ORDER; i++) comb_dly[i] <= '0;
        end else begin
            comb_vld <= dec_fire;
            if (tick) dec_cnt <= dec_cnt + LOG_D'(1);
            if (dec_fire) begin
                comb_q <= comb_res;
                for (int i = 0; i < ORDER; i++) comb_dly[i] <= comb_in[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scaling and saturation to the PCM range
    // ------------------------------------------------------------------
    logic signed [EW-1:0] comb_ext;
    logic signed [EW-1:0] comb_shr;
    logic [DW-1:0]        sat_val;

    always_comb begin
        comb_ext = EW'($signed(comb_q));
        comb_shr = comb_ext >>> SHIFT;
        if (comb_shr > SAT_HI) begin
            sat_val = SAT_HI[DW-1:0];
        end else if (comb_shr < SAT_LO) begin
            sat_val = SAT_LO[DW-1:0];
        end else begin
            sat_val = comb_shr[DW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Settle gate and single-entry output register
    // ------------------------------------------------------------------
    logic [SET_W-1:0] settle_cnt;
    logic             settled;

    assign settled = (settle_cnt >= SET_W'(SETTLE));

    // A stalled sample is never overwritten; a result arriving during a stall is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            if (comb_vld && !settled) settle_cnt <= settle_cnt + SET_W'(1);
            if (comb_vld && settled && (!data_valid || data_ready)) begin
                data       <= sat_val;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef PDM_DROP_COUNT_EN
    logic drop_evt;

    assign drop_evt = comb_vld && settled && data_valid && !data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
